// File: rtl/dzcpu_useq_pkg.sv
// Shared encodings for the dzcpu microcode sequencer: control-field codes,
// sequencer states and the per-uop action decode.
package dzcpu_useq_pkg;

    localparam logic [3:0] CTL_OP         = 4'd0;
    localparam logic [3:0] CTL_INC        = 4'd1;
    localparam logic [3:0] CTL_EOF        = 4'd2;
    localparam logic [3:0] CTL_INC_EOF    = 4'd3;
    localparam logic [3:0] CTL_EOF_FU     = 4'd4;
    localparam logic [3:0] CTL_INC_EOF_FU = 4'd5;
    localparam logic [3:0] CTL_INC_EOF_Z  = 4'd6;
    localparam logic [3:0] CTL_INC_EOF_NZ = 4'd7;
    localparam logic [3:0] CTL_JPAGE      = 4'd8;
    localparam logic [3:0] CTL_UPD_FLAGS  = 4'd9;

    localparam int PAGE_CB = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DISP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PWAIT = 2'd3
    } useq_state_e;

    typedef struct packed {
        logic inc;
        logic eof;
        logic fu;
        logic jpage;
        logic step;
    } uop_act_t;

    // Unlisted codes fall through to a plain step, same as CTL_OP.
    function automatic uop_act_t decodeCtl(input logic [3:0] ctl, input logic flagZ);
        uop_act_t a;
        a = '0;
        case (ctl)
            CTL_INC:        begin a.inc = 1'b1; a.step = 1'b1; end
            CTL_EOF:        begin a.eof = 1'b1; end
            CTL_INC_EOF:    begin a.inc = 1'b1; a.eof = 1'b1; end
            CTL_EOF_FU:     begin a.eof = 1'b1; a.fu = 1'b1; end
            CTL_INC_EOF_FU: begin a.inc = 1'b1; a.eof = 1'b1; a.fu = 1'b1; end
            CTL_INC_EOF_Z:  begin a.inc = 1'b1; a.eof = flagZ; a.step = !flagZ; end
            CTL_INC_EOF_NZ: begin a.inc = 1'b1; a.eof = !flagZ; a.step = flagZ; end
            CTL_JPAGE:      begin a.inc = 1'b1; a.jpage = 1'b1; end
            CTL_UPD_FLAGS:  begin a.fu = 1'b1; a.step = 1'b1; end
            default:        begin a.step = 1'b1; end
        endcase
        return a;
    endfunction

endpackage

// File: rtl/dzcpu_useq_if.sv
// Opcode handshake, micro-op output and table-write bus of the sequencer.
// The master side is the fetch logic / loader, the slave side is the sequencer.
interface dzcpu_useq_if #(
    parameter int OP_W   = 8,
    parameter int UOP_W  = 13,
    parameter int PAGE_W = 1
);

    logic [OP_W-1:0]        iOp;
    logic                   iOpValid;
    logic                   oOpReady;
    logic                   iStall;
    logic                   iFlagZ;
    logic [UOP_W-1:0]       oUop;
    logic                   oUopValid;
    logic                   oIncPc;
    logic                   oEof;
    logic                   oFlagUpd;
    logic                   oFault;
    logic                   iTblWe;
    logic                   iTblSel;
    logic [PAGE_W+OP_W-1:0] iTblAddr;
    logic [UOP_W-1:0]       iTblData;

    modport master (
        output iOp, iOpValid, iStall, iFlagZ,
        output iTblWe, iTblSel, iTblAddr, iTblData,
        input  oOpReady, oUop, oUopValid, oIncPc, oEof, oFlagUpd, oFault
    );

    modport slave (
        input  iOp, iOpValid, iStall, iFlagZ,
        input  iTblWe, iTblSel, iTblAddr, iTblData,
        output oOpReady, oUop, oUopValid, oIncPc, oEof, oFlagUpd, oFault
    );

endinterface

// File: rtl/dzcpu_useq_ram.sv
// Single-clock RAM with a registered, read-first output port.
// Only the output register is reset; the array keeps its contents.
module dzcpu_useq_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Holding re_i low keeps the last word, which is how stalls freeze oUop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/dzcpu_useq.sv
// Table-driven microcode sequencer: opcode dispatch through a paged table,
// micro-PC sequencing over a writable uop store, prefix pages and conditional EOF.
module dzcpu_useq
    import dzcpu_useq_pkg::*;
#(
    parameter int OP_W   = 8,
    parameter int UPC_W  = 8,
    parameter int UOP_W  = 13,
    parameter int CTL_W  = 4,
    parameter int PAGE_W = 1
) (
    input logic         iClock,
    input logic         iReset,
    dzcpu_useq_if.slave bus
);

    useq_state_e         state_q;
    logic [UPC_W-1:0]    upc_q;
    logic [UPC_W-1:0]    upc_d;
    logic [PAGE_W-1:0]   page_q;
    logic                fault_q;

    logic [UPC_W-1:0]    dispData;
    logic [UOP_W-1:0]    uopData;
    logic [CTL_W-1:0]    ctlField;
    uop_act_t            act;

    logic                opReady;
    logic                accept;
    logic                inRun;
    logic                advance;
    logic                overrun;
    logic                finish;
    logic                storeRe;

    dzcpu_useq_ram #(
        .AW (PAGE_W + OP_W),
        .DW (UPC_W)
    ) u_dispatch (
        .clk_i   (iClock),
        .rst_i   (iReset),
        .we_i    (bus.iTblWe && !bus.iTblSel),
        .waddr_i (bus.iTblAddr),
        .wdata_i (bus.iTblData[UPC_W-1:0]),
        .re_i    (accept),
        .raddr_i ({page_q, bus.iOp}),
        .rdata_o (dispData)
    );

    dzcpu_useq_ram #(
        .AW (UPC_W),
        .DW (UOP_W)
    ) u_store (
        .clk_i   (iClock),
        .rst_i   (iReset),
        .we_i    (bus.iTblWe && bus.iTblSel),
        .waddr_i (bus.iTblAddr[UPC_W-1:0]),
        .wdata_i (bus.iTblData),
        .re_i    (storeRe),
        .raddr_i (upc_d),
        .rdata_o (uopData)
    );

    // The store is addressed with the next uPC so its registered output lines
    // up with upc_q; a step off the last line is an overrun, not a wrap.
    always_comb begin
        ctlField = uopData[UOP_W-1 -: CTL_W];
        act      = decodeCtl(ctlField, bus.iFlagZ);
        opReady  = !iReset && (state_q == ST_IDLE || state_q == ST_PWAIT);
        accept   = opReady && bus.iOpValid;
        inRun    = (state_q == ST_RUN);
        advance  = inRun && !bus.iStall;
        overrun  = act.step && (upc_q == {UPC_W{1'b1}});
        finish   = act.eof || overrun;
        upc_d    = (state_q == ST_DISP) ? dispData : upc_q + UPC_W'(1);
        storeRe  = (state_q == ST_DISP) || (advance && act.step && !overrun);
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            page_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PWAIT: begin
                    if (bus.iOpValid) begin
                        state_q <= ST_DISP;
                    end
                end
                ST_DISP: begin
                    upc_q   <= upc_d;
                    page_q  <= '0;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (!bus.iStall) begin
                        if (act.jpage) begin
                            page_q  <= PAGE_W'(PAGE_CB);
                            state_q <= ST_PWAIT;
                        end else if (finish) begin
                            state_q <= ST_IDLE;
                            if (overrun) begin
                                fault_q <= 1'b1;
                            end
                        end else begin
                            upc_q <= upc_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-uop strobes decode the displayed word; only oIncPc waits out a stall.
    assign bus.oOpReady  = opReady;
    assign bus.oUop      = uopData;
    assign bus.oUopValid = inRun;
    assign bus.oIncPc    = advance && act.inc;
    assign bus.oEof      = inRun && finish;
    assign bus.oFlagUpd  = inRun && act.fu;
    assign bus.oFault    = fault_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Self-checking bench for dzcpu_useq: directed flows plus randomized tables,
// opcodes, stalls and Z flag, checked cycle by cycle against a table-walking model.
`timescale 1ns/1ps
module tb_dzcpu_useq;

    localparam int OP_W   = 8;
    localparam int UPC_W  = 8;
    localparam int UOP_W  = 13;
    localparam int CTL_W  = 4;
    localparam int PAGE_W = 1;

    localparam int K_OP         = 0;
    localparam int K_INC        = 1;
    localparam int K_EOF        = 2;
    localparam int K_INC_EOF    = 3;
    localparam int K_EOF_FU     = 4;
    localparam int K_INC_EOF_FU = 5;
    localparam int K_INC_EOF_Z  = 6;
    localparam int K_INC_EOF_NZ = 7;
    localparam int K_JPAGE      = 8;
    localparam int K_UPD_FLAGS  = 9;

    logic iClock = 1'b0;
    logic iReset;

    always #5 iClock = ~iClock;

    dzcpu_useq_if #(.OP_W(OP_W), .UOP_W(UOP_W), .PAGE_W(PAGE_W)) bus ();

    dzcpu_useq #(
        .OP_W   (OP_W),
        .UPC_W  (UPC_W),
        .UOP_W  (UOP_W),
        .CTL_W  (CTL_W),
        .PAGE_W (PAGE_W)
    ) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [UPC_W-1:0] mDisp  [0:511];
    logic [UOP_W-1:0] mStore [0:255];
    int               mPage;
    bit               mFault;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [UOP_W-1:0] mkUop(input int ctl, input int payload);
        logic [3:0] c;
        logic [8:0] p;
        c = ctl[3:0];
        p = payload[8:0];
        return {c, p};
    endfunction

    // Reference semantics of a control code, expressed as code sets.
    function automatic void refAction(input int ctl, input bit z,
                                      output bit inc, output bit eof, output bit fu, output bit jp);
        inc = ctl inside {K_INC, K_INC_EOF, K_INC_EOF_FU, K_INC_EOF_Z, K_INC_EOF_NZ, K_JPAGE};
        fu  = ctl inside {K_EOF_FU, K_INC_EOF_FU, K_UPD_FLAGS};
        jp  = (ctl == K_JPAGE);
        eof = (ctl inside {K_EOF, K_INC_EOF, K_EOF_FU, K_INC_EOF_FU})
              || (ctl == K_INC_EOF_Z && z) || (ctl == K_INC_EOF_NZ && !z);
    endfunction

    task automatic writeTable(input bit sel, input int addr, input int data);
        @(negedge iClock);
        bus.iTblWe   = 1'b1;
        bus.iTblSel  = sel;
        bus.iTblAddr = addr[8:0];
        bus.iTblData = data[12:0];
        @(posedge iClock);
        #1;
        bus.iTblWe = 1'b0;
        if (sel) mStore[addr[7:0]] = data[12:0];
        else     mDisp[addr[8:0]]  = data[7:0];
    endtask

    // Sends one opcode and follows its flow to the end, checking every cycle.
    task automatic applyStimulus(input int op, input bit z, input int stallPct, input int holdAt,
                                 input bit wrEn, input int wrAddr, input int wrData);
        int upc, steps, hold, incSeen, incExp;
        bit stall, inc, eof, fu, jp, over, done;
        logic [8:0] idx;
        logic [UOP_W-1:0] u;

        @(negedge iClock);
        bus.iOp      = op[7:0];
        bus.iOpValid = 1'b1;
        bus.iStall   = 1'b0;
        bus.iFlagZ   = z;
        #1;
        checkOutput("acceptReady", bus.oOpReady, 1);
        idx = {mPage[0], op[7:0]};
        upc = int'(mDisp[idx]);

        @(negedge iClock);
        bus.iOpValid = 1'b0;
        #1;
        checkOutput("dispValid", bus.oUopValid, 0);
        checkOutput("dispReady", bus.oOpReady, 0);
        mPage = 0;

        done = 0; steps = 0; hold = 0; incSeen = 0; incExp = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge iClock);
            if (wrEn && cyc == 1) begin
                bus.iTblWe   = 1'b1;
                bus.iTblSel  = 1'b0;
                bus.iTblAddr = wrAddr[8:0];
                bus.iTblData = 13'(wrData);
                mDisp[wrAddr[8:0]] = wrData[7:0];
            end else begin
                bus.iTblWe = 1'b0;
            end
            if (steps == holdAt && hold < 3) begin
                stall = 1;
                hold++;
            end else begin
                stall = ($urandom_range(0, 99) < stallPct);
            end
            bus.iStall = stall;
            #1;
            u = mStore[upc[7:0]];
            refAction(int'(u[12:9]), z, inc, eof, fu, jp);
            over = !eof && !jp && (upc == 255);
            checkOutput("uopValid", bus.oUopValid, 1);
            checkOutput("uop", bus.oUop, u);
            checkOutput("incPc", bus.oIncPc, inc && !stall);
            checkOutput("eof", bus.oEof, eof || over);
            checkOutput("flagUpd", bus.oFlagUpd, fu);
            checkOutput("fault", bus.oFault, mFault);
            if (bus.oIncPc) incSeen++;
            if (!stall) begin
                if (inc) incExp++;
                steps++;
                if (jp) begin
                    mPage = 1;
                    done  = 1;
                end else if (eof || over) begin
                    if (over) mFault = 1;
                    done = 1;
                end else begin
                    upc++;
                end
            end
        end
        checkOutput("flowDone", done, 1);

        @(negedge iClock);
        bus.iStall = 1'b0;
        bus.iTblWe = 1'b0;
        #1;
        checkOutput("incCount", incSeen, incExp);
        checkOutput("endValid", bus.oUopValid, 0);
        checkOutput("endReady", bus.oOpReady, 1);
        checkOutput("endFault", bus.oFault, mFault);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        iReset       = 1'b1;
        bus.iOp      = '0;
        bus.iOpValid = 1'b0;
        bus.iStall   = 1'b0;
        bus.iFlagZ   = 1'b0;
        bus.iTblWe   = 1'b0;
        bus.iTblSel  = 1'b0;
        bus.iTblAddr = '0;
        bus.iTblData = '0;
        mPage  = 0;
        mFault = 0;

        repeat (2) @(posedge iClock);
        #1;
        checkOutput("rstUop", bus.oUop, 0);
        checkOutput("rstValid", bus.oUopValid, 0);
        checkOutput("rstIncPc", bus.oIncPc, 0);
        checkOutput("rstEof", bus.oEof, 0);
        checkOutput("rstFlagUpd", bus.oFlagUpd, 0);
        checkOutput("rstFault", bus.oFault, 0);
        checkOutput("rstReady", bus.oOpReady, 0);
        @(negedge iClock);
        iReset = 1'b0;
        #1;
        checkOutput("readyAfterReset", bus.oOpReady, 1);

        for (int i = 0; i < 512; i++) writeTable(0, i, 0);
        for (int i = 0; i < 256; i++) writeTable(1, i, mkUop(K_INC_EOF, i));

        // Basic four-uop flow.
        writeTable(0, 'h031, 5);
        writeTable(1, 5, mkUop(K_INC, 'h11));
        writeTable(1, 6, mkUop(K_INC, 'h22));
        writeTable(1, 7, mkUop(K_OP, 'h33));
        writeTable(1, 8, mkUop(K_INC_EOF, 'h44));
        applyStimulus('h31, 0, 0, -1, 0, 0, 0);

        // Conditional end of flow on Z.
        writeTable(0, 'h040, 17);
        writeTable(1, 17, mkUop(K_OP, 'h101));
        writeTable(1, 18, mkUop(K_INC, 'h102));
        writeTable(1, 19, mkUop(K_INC_EOF_Z, 'h103));
        writeTable(1, 20, mkUop(K_UPD_FLAGS, 'h104));
        writeTable(1, 21, mkUop(K_OP, 'h105));
        writeTable(1, 22, mkUop(K_EOF_FU, 'h106));
        applyStimulus('h40, 1, 0, -1, 0, 0, 0);
        applyStimulus('h40, 0, 0, -1, 0, 0, 0);

        // CB prefix page, then the same opcode back on page 0.
        writeTable(0, 'h0CB, 40);
        writeTable(1, 40, mkUop(K_JPAGE, 'h0CB));
        writeTable(0, 'h17C, 16);
        writeTable(1, 16, mkUop(K_INC_EOF_FU, 'h07C));
        writeTable(0, 'h07C, 60);
        writeTable(1, 60, mkUop(K_INC, 'h060));
        writeTable(1, 61, mkUop(K_INC_EOF_NZ, 'h061));
        applyStimulus('hCB, 0, 0, -1, 0, 0, 0);
        applyStimulus('h7C, 0, 0, -1, 0, 0, 0);
        applyStimulus('h7C, 0, 0, -1, 0, 0, 0);

        // Three-cycle stall on the second INC uop plus random stalls.
        applyStimulus('h31, 0, 30, 1, 0, 0, 0);

        // Zero dispatch entry runs the flow at uPC 0.
        applyStimulus('h00, 0, 0, -1, 0, 0, 0);

        // Overwrite a dispatch entry mid-flow; the next dispatch sees it.
        applyStimulus('h31, 0, 0, -1, 1, 'h031, 17);
        applyStimulus('h31, 1, 0, -1, 0, 0, 0);

        // Overrun of the last store line.
        writeTable(0, 'h055, 254);
        writeTable(1, 254, mkUop(K_INC, 'h0FE));
        writeTable(1, 255, mkUop(K_OP, 'h0FF));
        applyStimulus('h55, 0, 0, -1, 0, 0, 0);
        applyStimulus('h40, 1, 0, -1, 0, 0, 0);

        // Reset in the middle of a flow.
        writeTable(0, 'h066, 30);
        writeTable(1, 30, mkUop(K_INC, 1));
        writeTable(1, 31, mkUop(K_INC, 2));
        writeTable(1, 32, mkUop(K_INC, 3));
        writeTable(1, 33, mkUop(K_EOF, 4));
        @(negedge iClock);
        bus.iOp      = 8'h66;
        bus.iOpValid = 1'b1;
        @(negedge iClock);
        bus.iOpValid = 1'b0;
        @(negedge iClock);
        #1;
        checkOutput("preResetValid", bus.oUopValid, 1);
        @(negedge iClock);
        iReset = 1'b1;
        #1;
        checkOutput("resetCycleReady", bus.oOpReady, 0);
        @(negedge iClock);
        iReset = 1'b0;
        #1;
        checkOutput("midRstUop", bus.oUop, 0);
        checkOutput("midRstValid", bus.oUopValid, 0);
        checkOutput("midRstIncPc", bus.oIncPc, 0);
        checkOutput("midRstEof", bus.oEof, 0);
        checkOutput("midRstFlagUpd", bus.oFlagUpd, 0);
        checkOutput("midRstFault", bus.oFault, 0);
        checkOutput("midRstReady", bus.oOpReady, 1);
        mFault = 0;
        mPage  = 0;

        // Randomized tables, opcodes, flags and stalls.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3))
                writeTable(1, $urandom_range(0, 255), mkUop($urandom_range(0, 15), $urandom));
            if ($urandom_range(0, 1) == 1)
                writeTable(0, $urandom_range(0, 511), $urandom_range(0, 255));
            applyStimulus($urandom_range(0, 255), 1'($urandom_range(0, 1)), 20, -1, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/dzcpu_useq.md
Name: dzcpu_useq

Overview:
- Parametrised, table-driven microcode sequencer; next generation of the hard-wired opcode-to-flow LUT and micro-op ROM.
- Holds two writable tables: a paged dispatch table (opcode to flow start) and a micro-op store.
- Accepts opcodes over a valid/ready handshake, runs the micro-op program counter, and resolves prefix-page jumps and conditional end-of-flow internally.
- Sits between the dzcpu fetch logic and the datapath decoder.

Parameters:
OP_W, 8, opcode width
UPC_W, 8, micro-PC width; uop store depth = 2**UPC_W
UOP_W, 13, micro-op width; control field is uop[UOP_W-1 -: CTL_W]
CTL_W, 4, control-field width
PAGE_W, 1, dispatch page select width (page 0 base, page 1 = CB prefix)

Ports:
iClock  in  1  clock
iReset  in  1  synchronous active-high reset
iOp  in  OP_W  opcode byte
iOpValid  in  1  opcode present
oOpReady  out  1  sequencer can take an opcode
iStall  in  1  datapath hold; freezes uPC and outputs
iFlagZ  in  1  current Z flag, for conditional end-of-flow
oUop  out  UOP_W  current micro-op
oUopValid  out  1  oUop is valid this cycle
oIncPc  out  1  one-cycle pulse: advance architectural PC
oEof  out  1  last uop of an instruction
oFlagUpd  out  1  flag update requested by this uop
oFault  out  1  sticky: uPC overran the store without EOF
iTblWe  in  1  table write strobe
iTblSel  in  1  0 = dispatch table, 1 = uop store
iTblAddr  in  PAGE_W+OP_W  dispatch: {page,op}; uop store: low UPC_W bits
iTblData  in  UOP_W  dispatch: low UPC_W bits = flow start

Behaviour:
- Reset:
  - oUop = 0, oUopValid = 0, oIncPc = 0, oEof = 0, oFlagUpd = 0, oFault = 0, oOpReady = 0 in the reset cycle and 1 afterwards.
  - State = IDLE, uPC = 0, page = 0.
  - Table contents are not cleared.
  - Reset mid-flow abandons the flow immediately with no further outputs.
- States: IDLE, DISP, RUN, PWAIT.
- IDLE:
  - oOpReady = 1.
  - When iOpValid & oOpReady, read dispatch[{page,iOp}] (registered) and go to DISP.
- DISP:
  - uPC <= dispatch data; read uop store; go to RUN.
  - oUopValid first rises 2 cycles after the accept cycle.
- RUN:
  - oUop = store[uPC] (registered read); oUopValid = 1.
  - If iStall: hold all outputs, uPC and state; oIncPc is not re-pulsed.
  - Otherwise the control field selects the action:
    - OP: uPC+1.
    - INC: oIncPc, uPC+1.
    - EOF: oEof, go to IDLE.
    - INC_EOF: oIncPc, oEof, go to IDLE.
    - EOF_FU and INC_EOF_FU: as EOF / INC_EOF, plus oFlagUpd.
    - UPD_FLAGS: oFlagUpd, uPC+1.
    - INC_EOF_Z: oIncPc; if iFlagZ, oEof and go to IDLE, else uPC+1.
    - INC_EOF_NZ: as INC_EOF_Z with !iFlagZ.
    - JPAGE: oIncPc; page <= 1; go to PWAIT.
- PWAIT:
  - oOpReady = 1, oUopValid = 0.
  - The next accepted opcode dispatches from page 1; page returns to 0 once that dispatch completes.
- Back-to-back flows: oOpReady rises in the cycle after an EOF uop, so there are at least 2 bubble cycles between flows.
- Opcode with a zero dispatch entry: runs the flow at uPC 0 (default single-byte op).
- Wrap-around: non-EOF uop at uPC = 2**UPC_W-1 sets oFault, forces oEof, and returns to IDLE. oFault clears only on reset.
- Table writes:
  - Accepted in any state and visible from the next cycle.
  - A same-cycle read of the address being written returns the old data.
  - A write to the uop line currently displayed does not alter oUop until uPC changes.
- Control-field codes not listed behave as OP.

Decomposition:
- Shared package dzcpu_useq_pkg holds:
  - CTL_* control encodings: OP=0, INC=1, EOF=2, INC_EOF=3, EOF_FU=4, INC_EOF_FU=5, INC_EOF_Z=6, INC_EOF_NZ=7, JPAGE=8, UPD_FLAGS=9.
  - State encodings.
  - PAGE_CB = 1.
- One sub-module, dzcpu_useq_ram: a single-clock, synchronous read-first RAM, instantiated twice (dispatch 2**(PAGE_W+OP_W) x UPC_W; store 2**UPC_W x UOP_W).

Test Plan:
- Load dispatch[0x31] = 5 and store[5..8] = {INC, INC, OP, INC_EOF}; send 0x31 -> oUopValid 2 cycles after accept, 4 uops, oIncPc 3 times, oEof on the 4th only, oOpReady returns.
- Flow at 17 with INC_EOF_Z at 19: iFlagZ = 1 -> oEof at 19; iFlagZ = 0 -> execution continues to 20..22 and ends at 22.
- Opcode 0xCB mapped to a JPAGE flow, then opcode 0x7C with dispatch[{1,0x7C}] = 16 -> flow 16 runs; a following 0x7C uses page 0.
- Hold iStall for 3 cycles mid-flow -> oUop is stable, uPC is frozen, and exactly one oIncPc per INC uop.
- Flow starting at 254 with no EOF -> oFault = 1, forced oEof at 255, return to IDLE; assert iReset mid-flow -> all outputs 0 on the next cycle.
- Overwrite dispatch[0x31] while a flow is running -> the current flow is unaffected; the next 0x31 uses the new entry.
